// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception entry controller: ExcCodes, CP0 addresses,
// Status bit indices, FSM encoding and the arbitration result type.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR      = 32'h0000_0020;
    localparam logic [31:0] STATUS_EXL_MASK = 32'h0000_0002;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SAVE_EPC   = 2'd1,
        SET_STATUS = 2'd2,
        ERET_ST    = 2'd3
    } exc_state_e;

    typedef enum logic [2:0] {
        TAKE_NONE    = 3'd0,
        TAKE_INT     = 3'd1,
        TAKE_EXC     = 3'd2,
        TAKE_EXC_EXL = 3'd3,
        TAKE_ERET    = 3'd4
    } exc_take_e;

    // Return address saved on entry: a delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
        epc_of = in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-point / CP0 bundle between the pipeline (master) and exc_ctrl (slave).
interface exc_ctrl_if;
    logic        inst_valid;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        eret;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_waddr;
    logic [31:0] wb_cp0_wdata;
    logic        timer_int;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  exccode;
    logic        bd;

    modport master (
        output inst_valid, pc, in_delay_slot, exc_valid, exc_code, eret,
               cp0_status, cp0_cause, cp0_epc, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, timer_int,
        input  stall, flush, new_pc, cp0_we, cp0_waddr, cp0_wdata, exccode, bd
    );

    modport slave (
        input  inst_valid, pc, in_delay_slot, exc_valid, exc_code, eret,
               cp0_status, cp0_cause, cp0_epc, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, timer_int,
        output stall, flush, new_pc, cp0_we, cp0_waddr, cp0_wdata, exccode, bd
    );
endinterface

// File: rtl/exc_ctrl_arb.sv
// exc_arb: CP0 write-back bypass, interrupt masking and event priority (combinational).
// EXC_TIMER_IRQ_EN folds timer_int into Cause.IP7 ahead of masking.
module exc_arb
    import exc_ctrl_pkg::*;
(
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic        in_delay_slot,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_wdata,
    input  logic        timer_int,
    output exc_take_e   take,
    output logic [4:0]  code,
    output logic        bd,
    output logic [31:0] epc_val,
    output logic [31:0] status_eff
);

    logic        wb_status_hit_s;
    logic        wb_cause_hit_s;
    logic        wb_epc_hit_s;
    logic [31:0] epc_eff_s;
    logic        ip7_s;
    logic [7:0]  ip_s;
    logic        int_pend_s;
    logic        unused_cause_s;

    assign wb_status_hit_s = wb_cp0_we & (wb_cp0_waddr == CP0_ADDR_STATUS);
    assign wb_cause_hit_s  = wb_cp0_we & (wb_cp0_waddr == CP0_ADDR_CAUSE);
    assign wb_epc_hit_s    = wb_cp0_we & (wb_cp0_waddr == CP0_ADDR_EPC);

    assign status_eff = wb_status_hit_s ? wb_cp0_wdata : cp0_status;
    assign epc_eff_s  = wb_epc_hit_s ? wb_cp0_wdata : cp0_epc;

`ifdef EXC_TIMER_IRQ_EN
    assign ip7_s = cp0_cause[15] | timer_int;
`else
    logic unused_timer_s;
    assign unused_timer_s = timer_int;
    assign ip7_s          = cp0_cause[15];
`endif

    // Only the software bits IP1..IP0 are writable, so only they are bypassed.
    assign ip_s = {ip7_s, cp0_cause[14:10], (wb_cause_hit_s ? wb_cp0_wdata[9:8] : cp0_cause[9:8])};
    assign unused_cause_s = ^{cp0_cause[31:16], cp0_cause[7:0]};

    assign int_pend_s = (|(ip_s & status_eff[15:8])) & status_eff[STATUS_IE]
                        & ~status_eff[STATUS_EXL] & inst_valid;

    assign bd = in_delay_slot;

    // Priority: interrupt, then synchronous exception, then ERET.
    always_comb begin
        take    = TAKE_NONE;
        code    = EXC_INT;
        epc_val = epc_of(pc, in_delay_slot);
        if (int_pend_s) begin
            take = TAKE_INT;
        end else if (inst_valid && exc_valid) begin
            take = status_eff[STATUS_EXL] ? TAKE_EXC_EXL : TAKE_EXC;
            code = exc_code;
        end else if (inst_valid && eret) begin
            take    = TAKE_ERET;
            epc_val = epc_eff_s;
        end else begin
            take = TAKE_NONE;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt entry controller: sequences CP0 EPC/Status writes, stall, flush and redirect.
// Optional build macro EXC_TIMER_IRQ_EN (see exc_arb) routes timer_int into IP7.
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);

    exc_take_e   take_s;
    logic [4:0]  code_s;
    logic        bd_s;
    logic [31:0] epc_val_s;
    logic [31:0] status_eff_s;

    exc_state_e  state_r;
    exc_state_e  next_state_s;
    logic        from_idle_s;
    logic        event_s;
    logic [31:0] status_lat_r;
    logic [31:0] src_status_s;

    logic        stall_nx_s, flush_nx_s, we_nx_s, bd_nx_s;
    logic [4:0]  waddr_nx_s, exccode_nx_s;
    logic [31:0] wdata_nx_s, new_pc_nx_s;
    logic        stall_r, flush_r, we_r, bd_r;
    logic [4:0]  waddr_r, exccode_r;
    logic [31:0] wdata_r, new_pc_r;

    exc_arb u_arb (
        .inst_valid    (bus.inst_valid),
        .pc            (bus.pc),
        .in_delay_slot (bus.in_delay_slot),
        .exc_valid     (bus.exc_valid),
        .exc_code      (bus.exc_code),
        .eret          (bus.eret),
        .cp0_status    (bus.cp0_status),
        .cp0_cause     (bus.cp0_cause),
        .cp0_epc       (bus.cp0_epc),
        .wb_cp0_we     (bus.wb_cp0_we),
        .wb_cp0_waddr  (bus.wb_cp0_waddr),
        .wb_cp0_wdata  (bus.wb_cp0_wdata),
        .timer_int     (bus.timer_int),
        .take          (take_s),
        .code          (code_s),
        .bd            (bd_s),
        .epc_val       (epc_val_s),
        .status_eff    (status_eff_s)
    );

    assign from_idle_s  = (state_r == IDLE);
    assign event_s      = from_idle_s && (take_s == TAKE_INT || take_s == TAKE_EXC || take_s == TAKE_EXC_EXL);
    assign src_status_s = from_idle_s ? status_eff_s : status_lat_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; triggers are only looked at from IDLE.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                case (take_s)
                    TAKE_INT, TAKE_EXC: next_state_s = SAVE_EPC;
                    TAKE_EXC_EXL:       next_state_s = SET_STATUS;
                    TAKE_ERET:          next_state_s = ERET_ST;
                    default:            next_state_s = IDLE;
                endcase
            end
            SAVE_EPC:   next_state_s = SET_STATUS;
            SET_STATUS: next_state_s = IDLE;
            ERET_ST:    next_state_s = IDLE;
            default:    next_state_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so the port registers line up with it.
    always_comb begin
        stall_nx_s   = 1'b0;
        flush_nx_s   = 1'b0;
        new_pc_nx_s  = 32'd0;
        we_nx_s      = 1'b0;
        waddr_nx_s   = 5'd0;
        wdata_nx_s   = 32'd0;
        case (next_state_s)
            SAVE_EPC: begin
                stall_nx_s  = 1'b1;
                flush_nx_s  = 1'b1;
                new_pc_nx_s = EXC_VECTOR;
                we_nx_s     = 1'b1;
                waddr_nx_s  = CP0_ADDR_EPC;
                wdata_nx_s  = epc_val_s;
            end
            SET_STATUS: begin
                stall_nx_s = 1'b1;
                we_nx_s    = 1'b1;
                waddr_nx_s = CP0_ADDR_STATUS;
                wdata_nx_s = src_status_s | STATUS_EXL_MASK;
                if (from_idle_s) begin
                    flush_nx_s  = 1'b1;
                    new_pc_nx_s = EXC_VECTOR;
                end else begin
                    flush_nx_s  = 1'b0;
                    new_pc_nx_s = 32'd0;
                end
            end
            ERET_ST: begin
                stall_nx_s  = 1'b1;
                flush_nx_s  = 1'b1;
                new_pc_nx_s = epc_val_s;
                we_nx_s     = 1'b1;
                waddr_nx_s  = CP0_ADDR_STATUS;
                wdata_nx_s  = src_status_s & ~STATUS_EXL_MASK;
            end
            default: begin
                stall_nx_s = 1'b0;
            end
        endcase
        if (event_s) begin
            exccode_nx_s = code_s;
            bd_nx_s      = bd_s;
        end else begin
            exccode_nx_s = exccode_r;
            bd_nx_s      = bd_r;
        end
    end

    // Output port registers and the Status snapshot used by the deferred SET_STATUS write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r      <= 1'b0;
            flush_r      <= 1'b0;
            new_pc_r     <= 32'd0;
            we_r         <= 1'b0;
            waddr_r      <= 5'd0;
            wdata_r      <= 32'd0;
            exccode_r    <= 5'd0;
            bd_r         <= 1'b0;
            status_lat_r <= 32'd0;
        end else begin
            stall_r   <= stall_nx_s;
            flush_r   <= flush_nx_s;
            new_pc_r  <= new_pc_nx_s;
            we_r      <= we_nx_s;
            waddr_r   <= waddr_nx_s;
            wdata_r   <= wdata_nx_s;
            exccode_r <= exccode_nx_s;
            bd_r      <= bd_nx_s;
            if (from_idle_s && take_s != TAKE_NONE) begin
                status_lat_r <= status_eff_s;
            end else begin
                status_lat_r <= status_lat_r;
            end
        end
    end

    assign bus.stall     = stall_r;
    assign bus.flush     = flush_r;
    assign bus.new_pc    = new_pc_r;
    assign bus.cp0_we    = we_r;
    assign bus.cp0_waddr = waddr_r;
    assign bus.cp0_wdata = wdata_r;
    assign bus.exccode   = exccode_r;
    assign bus.bd        = bd_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised + directed bench for exc_ctrl against a transaction-level reference model.
module tb_exc_ctrl;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] new_pc;
    } rec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic        t_iv, t_ds, t_ev, t_eret, t_wbwe, t_tmr;
    logic [31:0] t_pc, t_status, t_cause, t_epc, t_wbd;
    logic [4:0]  t_code, t_wba;
    logic [4:0]  exp_code;
    logic        exp_bd;

    exc_ctrl_if bus ();

    exc_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.inst_valid    = 1'b0;
        bus.pc            = 32'd0;
        bus.in_delay_slot = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_code      = 5'd0;
        bus.eret          = 1'b0;
        bus.cp0_status    = 32'd0;
        bus.cp0_cause     = 32'd0;
        bus.cp0_epc       = 32'd0;
        bus.wb_cp0_we     = 1'b0;
        bus.wb_cp0_waddr  = 5'd0;
        bus.wb_cp0_wdata  = 32'd0;
        bus.timer_int     = 1'b0;
    endtask

    // Triggers that would all fire from IDLE; the DUT must ignore them mid-sequence.
    task automatic drive_garbage();
        bus.inst_valid = 1'b1;
        bus.exc_valid  = 1'b1;
        bus.exc_code   = 5'd10;
        bus.eret       = 1'b1;
        bus.cp0_status = 32'h0000_FF01;
        bus.cp0_cause  = 32'h0000_FF00;
        bus.timer_int  = 1'b1;
        bus.pc         = 32'h0BAD_0000;
    endtask

    task automatic set_txn(input logic iv, input logic [31:0] pc, input logic ds, input logic ev,
                           input logic [4:0] code, input logic er, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep, input logic wbwe,
                           input logic [4:0] wba, input logic [31:0] wbd);
        t_iv = iv; t_pc = pc; t_ds = ds; t_ev = ev; t_code = code; t_eret = er;
        t_status = st; t_cause = ca; t_epc = ep; t_wbwe = wbwe; t_wba = wba; t_wbd = wbd;
        t_tmr = 1'b0;
    endtask

    task automatic do_txn();
        rec_t        exp_q[$];
        rec_t        r;
        logic [31:0] st, ep, ca;
        logic        intr, exc, er, taken;
        st = (t_wbwe && t_wba == 5'd12) ? t_wbd : t_status;
        ep = (t_wbwe && t_wba == 5'd14) ? t_wbd : t_epc;
        ca = t_cause;
        if (t_wbwe && t_wba == 5'd13) ca[9:8] = t_wbd[9:8];
`ifdef EXC_TIMER_IRQ_EN
        ca[15] = ca[15] | t_tmr;
`endif
        intr = t_iv && st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
        exc  = t_iv && t_ev;
        er   = t_iv && t_eret;
        if (intr || (exc && !st[1])) begin
            exp_q.push_back('{1'b1, 1'b1, 1'b1, 5'd14, (t_ds ? t_pc - 32'd4 : t_pc), 32'h20});
            exp_q.push_back('{1'b1, 1'b0, 1'b1, 5'd12, (st | 32'h2), 32'd0});
            exp_code = intr ? 5'd0 : t_code;
            exp_bd   = t_ds;
        end else if (exc) begin
            exp_q.push_back('{1'b1, 1'b1, 1'b1, 5'd12, (st | 32'h2), 32'h20});
            exp_code = t_code;
            exp_bd   = t_ds;
        end else if (er) begin
            exp_q.push_back('{1'b1, 1'b1, 1'b1, 5'd12, (st & ~32'h2), ep});
        end
        taken = (exp_q.size() != 0);
        while (exp_q.size() < 3) exp_q.push_back('0);

        @(negedge clk);
        bus.inst_valid = t_iv;     bus.pc = t_pc;           bus.in_delay_slot = t_ds;
        bus.exc_valid = t_ev;      bus.exc_code = t_code;   bus.eret = t_eret;
        bus.cp0_status = t_status; bus.cp0_cause = t_cause; bus.cp0_epc = t_epc;
        bus.wb_cp0_we = t_wbwe;    bus.wb_cp0_waddr = t_wba; bus.wb_cp0_wdata = t_wbd;
        bus.timer_int = t_tmr;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            r = exp_q[c];
            chk($sformatf("c%0d stall", c), 32'(bus.stall), 32'(r.stall));
            chk($sformatf("c%0d flush", c), 32'(bus.flush), 32'(r.flush));
            chk($sformatf("c%0d cp0_we", c), 32'(bus.cp0_we), 32'(r.we));
            chk($sformatf("c%0d cp0_waddr", c), 32'(bus.cp0_waddr), 32'(r.waddr));
            chk($sformatf("c%0d cp0_wdata", c), bus.cp0_wdata, r.wdata);
            chk($sformatf("c%0d new_pc", c), bus.new_pc, r.new_pc);
            if (c == 0 && taken) drive_garbage();
            else drive_idle();
        end
        chk("exccode", 32'(bus.exccode), 32'(exp_code));
        chk("bd", 32'(bus.bd), 32'(exp_bd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(bus.stall), 32'd0);
        chk({tag, " flush"}, 32'(bus.flush), 32'd0);
        chk({tag, " cp0_we"}, 32'(bus.cp0_we), 32'd0);
        chk({tag, " cp0_waddr"}, 32'(bus.cp0_waddr), 32'd0);
        chk({tag, " cp0_wdata"}, bus.cp0_wdata, 32'd0);
        chk({tag, " new_pc"}, bus.new_pc, 32'd0);
        chk({tag, " exccode"}, 32'(bus.exccode), 32'd0);
        chk({tag, " bd"}, 32'(bus.bd), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_code = 5'd0;
        exp_bd = 1'b0;
        rst = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Syscall, delay-slot overflow, PC wrap on delay slot
        set_txn(1'b1, 32'h100, 1'b0, 1'b1, 5'd8, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        set_txn(1'b1, 32'h204, 1'b1, 1'b1, 5'd12, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        set_txn(1'b1, 32'h0, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        // Interrupt beats exception; then EXL masks the interrupt
        set_txn(1'b1, 32'h480, 1'b0, 1'b1, 5'd10, 1'b0, 32'h0000_0401, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        set_txn(1'b1, 32'h484, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0403, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        set_txn(1'b1, 32'h488, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0000_0403, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        do_txn();
        // ERET with EPC bypassed from write-back; software interrupt bypassed via Cause
        set_txn(1'b1, 32'h600, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0003, 32'd0, 32'd0, 1'b1, 5'd14, 32'h3000);
        do_txn();
        set_txn(1'b1, 32'h700, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0101, 32'd0, 32'd0, 1'b1, 5'd13, 32'h100);
        do_txn();
        // Status bypass turning EXL on for an exception
        set_txn(1'b1, 32'h800, 1'b0, 1'b1, 5'd8, 1'b0, 32'h0000_0001, 32'd0, 32'd0, 1'b1, 5'd12, 32'h0000_0003);
        do_txn();

        // Reset mid-SAVE_EPC
        set_txn(1'b1, 32'h100, 1'b0, 1'b1, 5'd8, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.pc = 32'h100; bus.exc_valid = 1'b1; bus.exc_code = 5'd8;
        bus.cp0_status = 32'h1000_0001;
        @(posedge clk);
        #2;
        chk("mid cp0_we", 32'(bus.cp0_we), 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("async rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst edge");
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        exp_code = 5'd0;
        exp_bd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post rst c%0d cp0_we", c), 32'(bus.cp0_we), 32'd0);
            chk($sformatf("post rst c%0d stall", c), 32'(bus.stall), 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [31:0] pcv, stv, cav;
            logic [4:0]  cd, wa;
            pcv = $urandom;
            pcv[1:0] = 2'b00;
            stv = $urandom;
            stv[1] = ($urandom_range(0, 3) == 0);
            cav = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 3))
                0: cd = 5'd8;
                1: cd = 5'd9;
                2: cd = 5'd10;
                default: cd = 5'd12;
            endcase
            case ($urandom_range(0, 3))
                0: wa = 5'd12;
                1: wa = 5'd13;
                2: wa = 5'd14;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            set_txn(($urandom_range(0, 7) != 0), pcv, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), cd, ($urandom_range(0, 3) == 0), stv, cav,
                    $urandom, ($urandom_range(0, 1) == 1), wa, $urandom);
            t_tmr = ($urandom_range(0, 3) == 0);
            do_txn();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
